// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic ranging blocks.
// Provides: FSM state encoding (one-hot), distance width and timeout code,
// default echo-us-per-cm ratio and a small constant max helper.
package ultrasonic_pkg;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_TRIG      = 5'b00010,
    S_WAIT_RISE = 5'b00100,
    S_MEASURE   = 5'b01000,
    S_GUARD     = 5'b10000
  } state_t;

  localparam int unsigned       DIST_W        = 9;
  localparam logic [DIST_W-1:0] DIST_TIMEOUT  = 9'h1FF;
  localparam int unsigned       US_PER_CM_DEF = 58;

  // Larger of two constants, used to size the shared microsecond counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usec_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every CLK_MHZ clocks (1 us).
// Ports:
//   clk     - system clock
//   reset_p - synchronous active-high reset
//   tick    - registered 1 us strobe
module usec_tick_gen #(
  parameter int unsigned CLK_MHZ = 100
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // Count 0..CLK_MHZ-1 and flag the wrap.
  always_ff @(posedge clk) begin : presc
    if (reset_p) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_W'(CLK_MHZ - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/ultrasonic_scan_ctrl.sv
// Round-robin scheduler sharing one ranging engine across N_SENS HC-SR04 sensors.
// Ports:
//   clk, reset_p      - clock, synchronous active-high reset
//   scan_en           - run the scan loop
//   sens_mask         - per-sensor enable
//   echo              - raw asynchronous echo pins
//   trig              - trigger pins (one-hot or zero)
//   dist_cm_flat      - per-sensor distance in cm, sensor i at [9i+8:9i]
//   timeout_flags     - last ping of sensor i timed out
//   dist_valid        - one-cycle pulse on every result write
//   dist_id           - sensor index of the current/last ping
//   busy              - engine not idle
module ultrasonic_scan_ctrl
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_MHZ     = 100,
  parameter int unsigned N_SENS      = 4,
  parameter int unsigned TRIG_US     = 12,
  parameter int unsigned RISE_TO_US  = 5000,
  parameter int unsigned ECHO_MAX_US = 25000,
  parameter int unsigned GUARD_US    = 60000,
  parameter int unsigned US_PER_CM   = US_PER_CM_DEF
) (
  input  logic                       clk,
  input  logic                       reset_p,
  input  logic                       scan_en,
  input  logic [N_SENS-1:0]          sens_mask,
  input  logic [N_SENS-1:0]          echo,
  output logic [N_SENS-1:0]          trig,
  output logic [N_SENS*DIST_W-1:0]   dist_cm_flat,
  output logic [N_SENS-1:0]          timeout_flags,
  output logic                       dist_valid,
  output logic [2:0]                 dist_id,
  output logic                       busy
);

  localparam int unsigned US_MAX = max_u(max_u(TRIG_US, RISE_TO_US), max_u(ECHO_MAX_US, GUARD_US));
  localparam int unsigned US_W   = $clog2(US_MAX + 1);
  localparam int unsigned SUB_W  = $clog2(US_PER_CM + 1);
  localparam int unsigned ID_W   = 3;
  localparam logic [DIST_W-1:0] CM_SAT = '1;

  state_t                   r_state, w_state_nxt;
  logic [US_W-1:0]          r_us_cnt, w_us_nxt;
  logic [SUB_W-1:0]         r_sub_cnt, w_sub_nxt;
  logic [DIST_W-1:0]        r_cm_cnt, w_cm_nxt;
  logic [ID_W-1:0]          r_last, w_last_nxt, r_id, w_id_nxt, w_sel_idx;
  logic                     w_sel_found;
  logic [N_SENS-1:0]        r_trig, w_trig_nxt, r_flags, w_flags_nxt;
  logic [N_SENS*DIST_W-1:0] r_dist, w_dist_nxt;
  logic                     r_valid, w_valid_nxt, r_busy, w_timeout;
  logic [N_SENS-1:0]        r_echo_s1, r_echo_s2;
  logic                     r_echo_sel, r_echo_prev, w_echo_pick, w_rise, w_fall;
  logic                     w_tick;

  usec_tick_gen #(.CLK_MHZ(CLK_MHZ)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick    (w_tick)
  );

  // Echo synchronizer, selected-sensor mux register and previous-value register.
  always_ff @(posedge clk) begin : echo_sync
    if (reset_p) begin
      r_echo_s1   <= '0;
      r_echo_s2   <= '0;
      r_echo_sel  <= 1'b0;
      r_echo_prev <= 1'b0;
    end else begin
      r_echo_s1   <= echo;
      r_echo_s2   <= r_echo_s1;
      r_echo_sel  <= w_echo_pick;
      r_echo_prev <= r_echo_sel;
    end
  end

  always_comb begin : echo_mux
    w_echo_pick = 1'b0;
    for (int i = 0; i < int'(N_SENS); i++)
      if (ID_W'(i) == r_id) w_echo_pick = r_echo_s2[i];
  end

  assign w_rise = r_echo_sel & ~r_echo_prev;
  assign w_fall = ~r_echo_sel & r_echo_prev;

  // First enabled sensor after the last-served one, wrapping around.
  always_comb begin : next_sensor
    w_sel_idx   = '0;
    w_sel_found = 1'b0;
    for (int k = 1; k <= int'(N_SENS); k++)
      for (int i = 0; i < int'(N_SENS); i++)
        if (!w_sel_found && sens_mask[i] && (i == (int'(r_last) + k) % int'(N_SENS))) begin
          w_sel_found = 1'b1;
          w_sel_idx   = ID_W'(i);
        end
  end

  always_ff @(posedge clk) begin : state_reg
    if (reset_p) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and next-value logic for the ranging engine.
  always_comb begin : fsm_next
    w_state_nxt = r_state;
    w_us_nxt    = r_us_cnt;
    w_sub_nxt   = r_sub_cnt;
    w_cm_nxt    = r_cm_cnt;
    w_last_nxt  = r_last;
    w_id_nxt    = r_id;
    w_trig_nxt  = r_trig;
    w_dist_nxt  = r_dist;
    w_flags_nxt = r_flags;
    w_valid_nxt = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      // Pings start on a tick so the trigger width is an exact number of clocks.
      S_IDLE: begin
        if (w_tick && scan_en && w_sel_found) begin
          w_id_nxt   = w_sel_idx;
          w_us_nxt   = '0;
          w_trig_nxt = '0;
          for (int i = 0; i < int'(N_SENS); i++)
            if (ID_W'(i) == w_sel_idx) w_trig_nxt[i] = 1'b1;
          w_state_nxt = S_TRIG;
        end
      end
      S_TRIG: begin
        if (w_tick) begin
          if (r_us_cnt == US_W'(TRIG_US - 1)) begin
            w_trig_nxt  = '0;
            w_us_nxt    = '0;
            w_sub_nxt   = '0;
            w_cm_nxt    = '0;
            w_state_nxt = S_WAIT_RISE;
          end else begin
            w_us_nxt = r_us_cnt + US_W'(1);
          end
        end
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_us_nxt    = '0;
          w_sub_nxt   = '0;
          w_cm_nxt    = '0;
          w_state_nxt = S_MEASURE;
        end else if (w_tick) begin
          if (r_us_cnt == US_W'(RISE_TO_US - 1)) w_timeout = 1'b1;
          else                                   w_us_nxt  = r_us_cnt + US_W'(1);
        end
      end
      // Falling edge is checked first so it wins over a coincident max tick.
      S_MEASURE: begin
        if (w_fall) begin
          for (int i = 0; i < int'(N_SENS); i++)
            if (ID_W'(i) == r_id) begin
              w_dist_nxt[i*DIST_W +: DIST_W] = r_cm_cnt;
              w_flags_nxt[i]                 = 1'b0;
            end
          w_valid_nxt = 1'b1;
          w_us_nxt    = '0;
          w_state_nxt = S_GUARD;
        end else if (w_tick) begin
          if (r_us_cnt == US_W'(ECHO_MAX_US - 1)) begin
            w_timeout = 1'b1;
          end else begin
            w_us_nxt = r_us_cnt + US_W'(1);
            if (r_sub_cnt == SUB_W'(US_PER_CM - 1)) begin
              w_sub_nxt = '0;
              if (r_cm_cnt != CM_SAT) w_cm_nxt = r_cm_cnt + DIST_W'(1);
            end else begin
              w_sub_nxt = r_sub_cnt + SUB_W'(1);
            end
          end
        end
      end
      S_GUARD: begin
        if (w_tick) begin
          if (r_us_cnt == US_W'(GUARD_US - 1)) begin
            w_last_nxt  = r_id;
            w_us_nxt    = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_us_nxt = r_us_cnt + US_W'(1);
          end
        end
      end
      default: begin
        w_trig_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
    // Either timeout writes the marker code and flags the slot.
    if (w_timeout) begin
      for (int i = 0; i < int'(N_SENS); i++)
        if (ID_W'(i) == r_id) begin
          w_dist_nxt[i*DIST_W +: DIST_W] = DIST_TIMEOUT;
          w_flags_nxt[i]                 = 1'b1;
        end
      w_valid_nxt = 1'b1;
      w_us_nxt    = '0;
      w_state_nxt = S_GUARD;
    end
  end

  always_ff @(posedge clk) begin : dp_regs
    if (reset_p) begin
      r_us_cnt  <= '0;
      r_sub_cnt <= '0;
      r_cm_cnt  <= '0;
      r_last    <= ID_W'(N_SENS - 1);
      r_id      <= '0;
      r_trig    <= '0;
      r_dist    <= '0;
      r_flags   <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_us_cnt  <= w_us_nxt;
      r_sub_cnt <= w_sub_nxt;
      r_cm_cnt  <= w_cm_nxt;
      r_last    <= w_last_nxt;
      r_id      <= w_id_nxt;
      r_trig    <= w_trig_nxt;
      r_dist    <= w_dist_nxt;
      r_flags   <= w_flags_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign trig          = r_trig;
  assign dist_cm_flat  = r_dist;
  assign timeout_flags = r_flags;
  assign dist_valid    = r_valid;
  assign dist_id       = r_id;
  assign busy          = r_busy;

endmodule

// File: doc/ultrasonic_scan_ctrl.md
Name: ultrasonic_scan_ctrl

Overview:
Round-robin scheduler that shares one ranging engine between up to N_SENS HC-SR04-class sensors. Pings are strictly one at a time to avoid acoustic crosstalk.
For each enabled sensor it issues the trigger pulse, times the echo in microseconds, converts the width to centimetres without a divider, and stores a per-sensor result.
Sits between the board sensor pins and the display/LED logic.

Parameters:
CLK_MHZ, 100, system clock in MHz; sets the 1 us tick prescale.
N_SENS, 4, number of sensors (1..8).
TRIG_US, 12, trigger high time in us.
RISE_TO_US, 5000, max wait from trigger end to echo rising edge.
ECHO_MAX_US, 25000, max echo high time before timeout.
GUARD_US, 60000, quiet time after each ping before the next one.
US_PER_CM, 58, echo microseconds per centimetre.

Ports:
clk  in  1  system clock
reset_p  in  1  synchronous, active-high reset
scan_en  in  1  1 = run the scan loop
sens_mask  in  N_SENS  per-sensor enable
echo  in  N_SENS  raw asynchronous echo pins
trig  out  N_SENS  trigger pins, one-hot or zero
dist_cm_flat  out  N_SENS*9  packed distances; sensor i at [9i+8:9i]
timeout_flags  out  N_SENS  1 = last ping of sensor i timed out
dist_valid  out  1  one-cycle pulse when a result is written
dist_id  out  3  sensor index of the current/last ping
busy  out  1  state != IDLE

Behaviour:
- Reset (sync, reset_p=1 at a clk rising edge):
  - state=IDLE, trig=0, dist_cm_flat=0, timeout_flags=0, dist_valid=0, dist_id=0, busy=0.
  - Last-served pointer = N_SENS-1, so sensor 0 is served first.
  - Reset mid-ping drops trig on that same edge; no result is written.
- us tick: one-cycle pulse every CLK_MHZ clocks from a free-running prescaler. All us counters advance only on the tick.
- Echo: 2-flop synchronizer on all bits, then a mux picks the selected sensor. Edge detection uses the registered previous value. Latency from pin to edge flag is 3 clk.
- IDLE:
  - If scan_en=1 and (sens_mask!=0), select the next set mask bit after the last-served index, wrapping around.
  - Latch the index into dist_id, clear us_cnt, go to TRIG.
  - Otherwise stay in IDLE.
- TRIG: trig[dist_id]=1. When us_cnt reaches TRIG_US, drive trig=0, clear counters, go to WAIT_RISE.
- WAIT_RISE:
  - Echo rising edge: clear us_cnt, sub_cnt and cm_cnt, go to MEASURE.
  - us_cnt reaches RISE_TO_US first: timeout, go to GUARD.
  - An echo already high on entry (stuck high) never produces an edge, so it ends in timeout.
- MEASURE, on each tick:
  - sub_cnt increments; at US_PER_CM-1 it wraps to 0 and cm_cnt increments.
  - cm_cnt saturates at 511. Result is floor(us/58).
  - Falling edge: write cm_cnt to slot dist_id, clear timeout_flags[dist_id], pulse dist_valid, go to GUARD.
  - us_cnt reaches ECHO_MAX_US: timeout.
  - Falling edge and max reached in the same cycle: the falling edge wins.
- Timeout (either state):
  - slot dist_id := 9'h1FF, timeout_flags[dist_id]=1, pulse dist_valid.
- GUARD: wait GUARD_US, then update the last-served pointer to dist_id and go to IDLE.
- Mask or scan_en changes mid-ping do not abort the ping. They take effect at the next IDLE selection.
- Echoes of unselected sensors are ignored.
- Slots of disabled sensors keep their last value.

Decomposition:
- Shared package ultrasonic_pkg holds:
  - state encodings S_IDLE/S_TRIG/S_WAIT_RISE/S_MEASURE/S_GUARD (one-hot, 5 bits);
  - DIST_W=9 and DIST_TIMEOUT=9'h1FF;
  - the default US_PER_CM.
- One sub-module, usec_tick_gen (prescaler: clk, reset_p, tick output), reusable by the other sensor blocks.

Test Plan:
- Mask=4'b0001, echo[0] rises 300 us after trig falls and stays high 580 us -> trig[0] high exactly 1200 clk, dist_valid with dist_id=0, slot0=10, timeout_flags=0.
- Mask=4'b1011, each echo 1160 us -> serve order 0,1,3,0; slots 0,1,3=20; slot2 untouched=0; a GUARD of 60000 us between pings.
- Echo high 57 us -> 0 cm; 58 us -> 1 cm; 115 us -> 1 cm; 116 us -> 2 cm.
- No echo rise -> timeout after 5000 us: slot=0x1FF, flag=1, dist_valid pulse. Next ping returning 10 cm -> flag clears, slot=10.
- Echo stuck high 30 ms -> timeout at 25000 us of high time. Falling edge and max tick in the same cycle -> valid result 431 cm.
- reset_p during MEASURE -> trig=0, no dist_valid. scan_en dropped during TRIG -> that ping completes, then the block stays in IDLE with busy=0.
